// File: rtl/dma_fifo.sv
// dma_fifo: show-ahead single-clock FIFO buffering words between DMA read and write phases.
module dma_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("dma_fifo: DEPTH must be a power of two >= 2");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty    = wr_ptr == rd_ptr;
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  // a pop in the same cycle frees the slot a full-FIFO push lands in
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge CLK)
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
endmodule

// File: tb/tb_dma_fifo.sv
// tb_dma_fifo: directed vector table plus hand-written full/wrap/reset sequences for dma_fifo.
module tb_dma_fifo;
  logic        CLK = 0, RSTN = 0, push = 0, pop = 0;
  logic [31:0] push_data = '0, pop_data;
  logic        full, empty;
  int          total = 0, bad = 0;

  dma_fifo #(.DATA_WIDTH(32), .DEPTH(16)) dut (
    .CLK(CLK), .RSTN(RSTN), .push(push), .push_data(push_data),
    .pop(pop), .pop_data(pop_data), .full(full), .empty(empty)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        push;
    logic [31:0] d;
    logic        pop;
    logic        e;
    logic        f;
    logic [31:0] q;
  } vec_t;
  vec_t v[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic p, input logic [31:0] d, input logic o);
    push = p; push_data = d; pop = o;
    @(posedge CLK); #1;
    push = 0; pop = 0;
  endtask

  logic [31:0] q[$];
  logic [31:0] nxt, exp_rd;
  logic        up, p, o;

  initial begin
    v[0] = '{0, 32'h0,         1, 1, 0, 32'h0};
    v[1] = '{1, 32'hA5A5_0001, 0, 0, 0, 32'hA5A5_0001};
    v[2] = '{1, 32'hA5A5_0002, 0, 0, 0, 32'hA5A5_0001};
    v[3] = '{1, 32'hA5A5_0003, 0, 0, 0, 32'hA5A5_0001};
    v[4] = '{0, 32'h0,         1, 0, 0, 32'hA5A5_0002};
    v[5] = '{0, 32'h0,         1, 0, 0, 32'hA5A5_0003};
    v[6] = '{0, 32'h0,         1, 1, 0, 32'h0};
    v[7] = '{0, 32'h0,         1, 1, 0, 32'h0};
    v[8] = '{1, 32'h1234,      1, 0, 0, 32'h1234};
    v[9] = '{0, 32'h0,         1, 1, 0, 32'h0};

    repeat (3) @(posedge CLK);
    #1 RSTN = 1;
    #1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_data", pop_data, 0);

    for (int i = 0; i < 10; i++) begin
      step(v[i].push, v[i].d, v[i].pop);
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(v[i].e));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(v[i].f));
      chk($sformatf("vec%0d_data", i), pop_data, v[i].q);
    end

    for (int i = 0; i < 16; i++) begin
      step(1, 32'h100 + i, 0);
      chk($sformatf("fill%0d_full", i), 32'(full), 32'(i == 15));
    end
    step(1, 32'hDEAD, 0);
    chk("drop_full", 32'(full), 1);
    chk("drop_head", pop_data, 32'h100);
    step(1, 32'hBEEF, 1);
    chk("pp_full", 32'(full), 1);
    chk("pp_head", pop_data, 32'h101);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), pop_data, i < 15 ? 32'h101 + i : 32'hBEEF);
      step(0, 0, 1);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_data", pop_data, 0);

    up = 1; nxt = 32'h2000; exp_rd = 32'h2000;
    for (int c = 0; c < 40; c++) begin
      if (q.size() == 5) up = 0;
      else if (q.size() == 0) up = 1;
      p = up || (c % 4 == 0);
      o = !up || (c % 3 == 0);
      if (o && q.size() > 0) begin
        chk($sformatf("wrap%0d_pop", c), pop_data, exp_rd);
        exp_rd++;
        void'(q.pop_front());
      end
      if (p) q.push_back(nxt);
      step(p, nxt, o);
      if (p) nxt++;
      chk($sformatf("wrap%0d_empty", c), 32'(empty), 32'(q.size() == 0));
      chk($sformatf("wrap%0d_head", c), pop_data, q.size() > 0 ? q[0] : 32'h0);
    end

    while (q.size() > 0) begin
      void'(q.pop_front());
      step(0, 0, 1);
    end
    for (int i = 0; i < 3; i++) step(1, 32'h300 + i, 0);
    chk("pre_rst_empty", 32'(empty), 0);
    chk("pre_rst_head", pop_data, 32'h300);
    #2 RSTN = 0;
    #1;
    chk("async_rst_empty", 32'(empty), 1);
    chk("async_rst_data", pop_data, 0);
    @(posedge CLK); #1 RSTN = 1;
    step(0, 0, 1);
    chk("post_rst_empty", 32'(empty), 1);
    chk("post_rst_full", 32'(full), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
